// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, scanner state enum and timing bundle.
// Colour-bar helper is used by the optional test-pattern build.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int CNT_W = 10;
    localparam int BAR_W = 80;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_SCAN
    } scan_state_t;

    typedef struct packed {
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] v;
        logic             pix_en;
        logic             hsync;
        logic             vsync;
        logic             frame_wrap;
    } vga_tm_t;

    function automatic logic [23:0] bar_rgb(input logic [CNT_W-1:0] h);
        logic [23:0] c;
        if (h < CNT_W'(1 * BAR_W))      c = 24'hFFFFFF;
        else if (h < CNT_W'(2 * BAR_W)) c = 24'hFFFF00;
        else if (h < CNT_W'(3 * BAR_W)) c = 24'h00FFFF;
        else if (h < CNT_W'(4 * BAR_W)) c = 24'h00FF00;
        else if (h < CNT_W'(5 * BAR_W)) c = 24'hFF00FF;
        else if (h < CNT_W'(6 * BAR_W)) c = 24'hFF0000;
        else if (h < CNT_W'(7 * BAR_W)) c = 24'h0000FF;
        else                            c = 24'h000000;
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA timing: 25 MHz pixel tick from 50 MHz clk,
// h/v counters and raw (unregistered) active-low syncs.
module vga_timing
    import vga_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    output vga_tm_t tm
);

    logic             phase;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_last;
    logic             v_last;

    assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            phase <= ~phase;
            if (phase) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        tm.h          = h_cnt;
        tm.v          = v_cnt;
        tm.pix_en     = phase;
        tm.hsync      = !(h_cnt >= CNT_W'(H_SYNC_START) &&
                          h_cnt <= CNT_W'(H_SYNC_END));
        tm.vsync      = !(v_cnt >= CNT_W'(V_SYNC_START) &&
                          v_cnt <= CNT_W'(V_SYNC_END));
        tm.frame_wrap = phase & h_last & v_last;
    end

endmodule

// File: rtl/vga_image_scanner.sv
// Scans an image RAM window onto VGA with a one-pixel RGB/sync pipeline.
// Define VGA_TEST_PATTERN_EN for colour bars while not scanning.
module vga_image_scanner
    import vga_pkg::*;
#(
    parameter logic [31:0] IMG_BASE = 32'd0,
    parameter int          IMG_W    = 256,
    parameter int          IMG_H    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] rdata,
    output logic [31:0] addr,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_done
);

    localparam int          W_SHIFT = $clog2(IMG_W);
    localparam logic [31:0] W_LIM   = 32'(IMG_W);
    localparam logic [31:0] H_LIM   = 32'(IMG_H);

    vga_tm_t     tm;
    scan_state_t state;
    logic        in_win;
    logic [31:0] h32;
    logic [31:0] v32;
    logic [23:0] idle_rgb;
    logic [23:0] pix_rgb;
    logic [23:0] rgb_q;
    logic        unused_rdata;

    vga_timing u_timing (
        .clk   (clk),
        .reset (reset),
        .tm    (tm)
    );

    assign h32 = {{(32-CNT_W){1'b0}}, tm.h};
    assign v32 = {{(32-CNT_W){1'b0}}, tm.v};

    assign in_win = (state == ST_SCAN) && (h32 < W_LIM) && (v32 < H_LIM);

    // Row stride is a power of two, so v*IMG_W is a plain shift.
    assign addr = in_win ? IMG_BASE + (v32 << W_SHIFT) + h32 : IMG_BASE;

`ifdef VGA_TEST_PATTERN_EN
    assign idle_rgb = (tm.h < CNT_W'(H_ACTIVE) && tm.v < CNT_W'(V_ACTIVE))
                    ? bar_rgb(tm.h) : 24'h0;
`else
    assign idle_rgb = 24'h0;
`endif

    always_comb begin
        pix_rgb = idle_rgb;
        if (in_win)
            pix_rgb = {3{rdata[7:0]}};
        else if (state == ST_SCAN)
            pix_rgb = 24'h0;
    end

    assign unused_rdata = ^rdata[31:8];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (enable)
                        state <= ST_ARM;
                end
                ST_ARM: begin
                    if (!enable)
                        state <= ST_IDLE;
                    else if (tm.frame_wrap)
                        state <= ST_SCAN;
                end
                ST_SCAN: begin
                    // A started frame always runs to its wrap.
                    if (tm.frame_wrap) begin
                        frame_done <= 1'b1;
                        if (!enable)
                            state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb_q <= 24'h0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (tm.pix_en) begin
            rgb_q <= pix_rgb;
            hsync <= tm.hsync;
            vsync <= tm.vsync;
        end
    end

    assign red   = rgb_q[23:16];
    assign green = rgb_q[15:8];
    assign blue  = rgb_q[7:0];

endmodule

// File: tb/tb_vga_image_scanner.sv
// Randomized bench for vga_image_scanner against a frame-level model.
// Honours VGA_TEST_PATTERN_EN when computing idle colours.
module tb_vga_image_scanner;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          W     = 256;
    localparam int          H     = 256;
    localparam int          FRAME = 800 * 525;
`ifdef VGA_TEST_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        frame_done;
    logic [23:0] rgb;
    logic [7:0]  seed;

    always #10 clk = ~clk;

    vga_image_scanner #(
        .IMG_BASE (BASE),
        .IMG_W    (W),
        .IMG_H    (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .rdata      (rdata),
        .addr       (addr),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_done (frame_done)
    );

    assign rgb = {red, green, blue};

    function automatic logic [7:0] mem_byte(input logic [31:0] a,
                                            input logic [7:0]  s);
        if (a == BASE)
            return 8'h5A;
        return a[7:0] ^ a[15:8] ^ s;
    endfunction

    always_comb rdata = {24'hA5C3E1, mem_byte(addr, seed)};

    function automatic logic [23:0] idle_rgb(input int h, input int v);
        if (PAT_EN && h < 640 && v < 480) begin
            case (h / 80)
                0: return 24'hFFFFFF;
                1: return 24'hFFFF00;
                2: return 24'h00FFFF;
                3: return 24'h00FF00;
                4: return 24'hFF00FF;
                5: return 24'hFF0000;
                6: return 24'h0000FF;
                default: return 24'h000000;
            endcase
        end
        return 24'h000000;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    bit scanned [0:7];
    bit en_last;
    int k;
    int e_addr, e_rgb, e_hs, e_vs, e_fd;

    task automatic flush();
        check("addr_track", 32'(e_addr), 32'd0);
        check("rgb_track", 32'(e_rgb), 32'd0);
        check("hsync_track", 32'(e_hs), 32'd0);
        check("vsync_track", 32'(e_vs), 32'd0);
        check("frame_done_track", 32'(e_fd), 32'd0);
        e_addr = 0; e_rgb = 0; e_hs = 0; e_vs = 0; e_fd = 0;
    endtask

    // One clk: advance the model at frame granularity, then compare pins.
    task automatic step();
        bit          en_b;
        int          n, f, h, v, m, hm, vm, fm;
        logic [31:0] ea;
        logic [23:0] er;
        logic        ehs, evs, efd;
        en_b = enable;
        @(posedge clk);
        k++;
        n = k / 2;
        if (k % 2 == 0 && n > 0 && n % FRAME == 0) begin
            f = n / FRAME;
            scanned[f] = en_b && (scanned[f-1] || en_last);
        end
        en_last = en_b;
        #1;
        h = n % 800;
        v = (n / 800) % 525;
        f = n / FRAME;
        ea = (scanned[f] && h < W && v < H) ? BASE + 32'(v * W + h) : BASE;
        if (n == 0) begin
            er = 24'h0; ehs = 1'b1; evs = 1'b1;
        end else begin
            m  = n - 1;
            hm = m % 800;
            vm = (m / 800) % 525;
            fm = m / FRAME;
            if (scanned[fm] && hm < W && vm < H)
                er = {3{mem_byte(BASE + 32'(vm * W + hm), seed)}};
            else if (scanned[fm])
                er = 24'h0;
            else
                er = idle_rgb(hm, vm);
            ehs = !(hm >= 656 && hm <= 751);
            evs = !(vm >= 490 && vm <= 491);
        end
        efd = (k % 2 == 0 && n > 0 && n % FRAME == 0 && scanned[n/FRAME-1]);
        if (addr !== ea)        e_addr++;
        if (rgb !== er)         e_rgb++;
        if (hsync !== ehs)      e_hs++;
        if (vsync !== evs)      e_vs++;
        if (frame_done !== efd) e_fd++;
        if (k % 1600 == 0)
            flush();
    endtask

    task automatic run_to(input int n_target);
        while (k < 2 * n_target + 1)
            step();
    endtask

    task automatic do_reset(input string tag);
        flush();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hsync"}, 32'(hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_rgb"}, 32'(rgb), 32'd0);
        check({tag, "_addr"}, addr, BASE);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        reset = 1'b1;
        k = 0;
        en_last = 1'b0;
        for (int i = 0; i < 8; i++)
            scanned[i] = 1'b0;
    endtask

    bit mon_on = 1'b0;
    bit hs_prev, hs_seen, vs_prev, vs_seen;
    int hs_run, hs_low, hs_since, hs_per;
    int vs_run, vs_low, vs_since, vs_per;
    int fd_hi;

    always @(posedge clk) begin
        if (!mon_on) begin
            hs_prev <= 1'b1; hs_seen <= 1'b0;
            hs_run <= 0; hs_low <= 0; hs_since <= 0; hs_per <= 0;
            vs_prev <= 1'b1; vs_seen <= 1'b0;
            vs_run <= 0; vs_low <= 0; vs_since <= 0; vs_per <= 0;
            fd_hi <= 0;
        end else begin
            hs_prev <= hsync;
            vs_prev <= vsync;
            if (!hsync) hs_run <= hs_run + 1;
            else if (hs_run != 0) begin hs_low <= hs_run; hs_run <= 0; end
            if (!vsync) vs_run <= vs_run + 1;
            else if (vs_run != 0) begin vs_low <= vs_run; vs_run <= 0; end
            if (hs_prev && !hsync) begin
                if (hs_seen) hs_per <= hs_since;
                hs_seen <= 1'b1;
                hs_since <= 1;
            end else begin
                hs_since <= hs_since + 1;
            end
            if (vs_prev && !vsync) begin
                if (vs_seen) vs_per <= vs_since;
                vs_seen <= 1'b1;
                vs_since <= 1;
            end else begin
                vs_since <= vs_since + 1;
            end
            if (frame_done) fd_hi <= fd_hi + 1;
        end
    end

    initial begin
        reset   = 1'b0;
        enable  = 1'b0;
        seed    = 8'($urandom);
        k       = 0;
        en_last = 1'b0;
        e_addr = 0; e_rgb = 0; e_hs = 0; e_vs = 0; e_fd = 0;
        for (int i = 0; i < 8; i++)
            scanned[i] = 1'b0;

        do_reset("por");
        repeat (2000 + $urandom_range(0, 500)) step();
        enable = 1'b1;
        repeat (3000 + $urandom_range(0, 999)) step();
        enable = 1'b0;
        do_reset("mid");
        mon_on = 1'b1;

        run_to(101);
        check("idle_rgb_h100", 32'(rgb), 32'(idle_rgb(100, 0)));

        run_to(200 * 800 + $urandom_range(0, 799));
        enable = 1'b1;
        run_to(210 * 800 + 11);
        check("arm_rgb", 32'(rgb), 32'(idle_rgb(10, 210)));
        check("arm_addr", addr, BASE);

        run_to(FRAME);
        check("scan_addr_00", addr, BASE);
        run_to(FRAME + 1);
        check("scan_rgb_00", 32'(rgb), 32'h5A5A5A);
        run_to(FRAME + 1 * 800 + 3);
        check("scan_addr_3_1", addr, BASE + 32'(1 * W + 3));

        run_to(FRAME + 100 * 800 + $urandom_range(0, 799));
        enable = 1'b0;
        run_to(FRAME + 200 * 800 + 50);
        check("rgb_after_drop", 32'(rgb),
              32'({3{mem_byte(BASE + 32'(200 * W + 49), seed)}}));

        run_to(FRAME + 255 * 800 + 255);
        check("addr_255_255", addr, BASE + 32'd65535);
        run_to(FRAME + 255 * 800 + 256);
        check("addr_h256", addr, BASE);
        run_to(FRAME + 255 * 800 + 257);
        check("rgb_h256", 32'(rgb), 32'd0);

        run_to(2 * FRAME + 10 * 800 + 10);
        check("done_addr", addr, BASE);
        run_to(2 * FRAME + 10 * 800 + 11);
        check("done_rgb", 32'(rgb), 32'(idle_rgb(10, 10)));

        flush();
        check("hsync_low_clks", 32'(hs_low), 32'd192);
        check("hsync_period_clks", 32'(hs_per), 32'd1600);
        check("vsync_low_clks", 32'(vs_low), 32'd3200);
        check("vsync_period_clks", 32'(vs_per), 32'd840000);
        check("frame_done_clks", 32'(fd_hi), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_image_scanner.md
VGA_IMAGE_SCANNER -- requirements
Module: vga_image_scanner

Interface
REQ-001 SHALL have parameter IMG_BASE, default 0: word address of image pixel (0,0) in image RAM.
REQ-002 SHALL have parameter IMG_W, default 256: image width in pixels; power of two.
REQ-003 SHALL have parameter IMG_H, default 256: image height in pixels.
REQ-004 SHALL have port clk  in  1: 50 MHz system clock; the only clock.
REQ-005 SHALL have port reset  in  1: synchronous, active-low reset.
REQ-006 SHALL have port enable  in  1: scan request (processor finished AND VGA enabled).
REQ-007 SHALL have port rdata  in  32: image RAM read data; pixel gray level in [7:0].
REQ-008 SHALL have port addr  out  32: image RAM word read address.
REQ-009 SHALL have ports red, green, blue  out  8 each: pixel colour.
REQ-010 SHALL have ports hsync, vsync  out  1 each: active-low syncs.
REQ-011 SHALL have port frame_done  out  1: one-clk pulse at the end of each scanned frame.

Function
REQ-012 SHALL generate pixel tick pix_en on every second clk (25 MHz); all counters advance only on pix_en.
REQ-013 SHALL count h 0..799 (active 640, front porch 16, sync 96, back porch 48) and v 0..524 (active 480, front porch 10, sync 2, back porch 33); v increments when h wraps 799->0; v wraps 524->0.
REQ-014 SHALL assert hsync low for h 656..751 and vsync low for v 490..491.
REQ-015 SHALL implement FSM IDLE, ARM, SCAN; IDLE->ARM when enable=1; ARM->SCAN on pix_en with h=799 and v=524; ARM->IDLE if enable drops.
REQ-016 SHALL, in SCAN with enable=0, complete the current frame and go to IDLE at the frame wrap; it SHALL NOT abort mid-frame.
REQ-017 SHALL drive addr = IMG_BASE + v*IMG_W + h (shift-add, 32-bit, no multiplier) when in SCAN with h<IMG_W and v<IMG_H; otherwise addr = IMG_BASE.
REQ-018 SHALL register red=green=blue=rdata[7:0] on the pix_en following the address for in-window pixels; black (0) outside the window, during blanking, and in IDLE/ARM.
REQ-019 SHALL delay hsync/vsync through the same one-pixel pipeline stage as RGB, so colour and syncs stay aligned (latency: counter state to pins = 1 pixel = 2 clk).
REQ-020 SHALL pulse frame_done for one clk at the SCAN frame wrap (h 799->0, v 524->0).
REQ-021 SHALL keep timing counters running in every state; only RGB/addr depend on state.

Reset
REQ-022 SHALL, when reset=0 at a clk edge, set h=0, v=0, pix_en phase=0, state=IDLE, addr=IMG_BASE, RGB=0, hsync=1, vsync=1, frame_done=0.
REQ-023 SHALL, on reset mid-frame, restart timing from (0,0) on the first clk after release and require a new ARM.

Configuration
REQ-024 SHALL, with VGA_TEST_PATTERN_EN defined, output eight 80-pixel vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black) in active area while IDLE/ARM; without it, output black there.

Structure
REQ-025 SHALL take timing constants (H/V active, porch, sync, totals) and the FSM state enum from shared package vga_pkg.
REQ-026 SHALL instantiate sub-module vga_timing (pix_en, h/v counters, raw syncs); scanner holds FSM, address, pipeline.

Verification
REQ-027 SHALL check: reset=0 held 3 clk -> hsync=vsync=1, RGB=0, addr=IMG_BASE, state IDLE.
REQ-028 SHALL check: free run -> hsync low 96 pixels (192 clk) every 800 pixels; vsync low 2 lines every 525 lines.
REQ-029 SHALL check: enable=1 mid-frame -> RGB stays 0 until next frame; at (h=0,v=0) addr=IMG_BASE; rdata=0x5A -> RGB=0x5A one pixel later.
REQ-030 SHALL check: SCAN, pixel (h=255,v=255) -> addr=IMG_BASE+65535; h=256 -> addr=IMG_BASE, RGB=0.
REQ-031 SHALL check: enable dropped at v=100 -> scanning continues to v=479, frame_done pulses once, then IDLE, RGB=0.
REQ-032 SHALL check: VGA_TEST_PATTERN_EN defined, IDLE, h=100 -> RGB=FF/FF/00 (yellow); undefined -> 00/00/00.
